// File: rtl/sf_param_loader_pkg.sv
// Shared definitions for the sf_* constant-memory host blocks: FSM encodings
// and the width of the saturating abort counter.
package sf_param_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FLUSH = 2'd2
    } sf_state_e;

    localparam int unsigned ABORT_W = 8;

endpackage

// File: rtl/sf_param_bank.sv
// Staging and latched constant banks. A snapshot copies the staging bank,
// including any word written on the same edge, into the latched bank.
module sf_param_bank #(
    parameter int pw         = 18,
    parameter int consts_len = 4,
    parameter int const_aw   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                lb_write,
    input  logic [const_aw-1:0] lb_addr,
    input  logic [pw-1:0]       lb_data,
    input  logic                snap,
    input  logic [const_aw-1:0] rd_idx,
    output logic [pw-1:0]       rd_data
);

    localparam logic [const_aw:0] LEN_W = (const_aw + 1)'(consts_len);

    logic [pw-1:0] staging_q [consts_len];
    logic [pw-1:0] staging_d [consts_len];
    logic [pw-1:0] latched_q [consts_len];
    logic [pw-1:0] latched_d [consts_len];
    logic          in_range;

    assign in_range = ({1'b0, lb_addr} < LEN_W);

    // Snapshot takes staging_d rather than staging_q so a same-edge host
    // write lands in the latched copy as well.
    always_comb begin
        staging_d = staging_q;
        latched_d = latched_q;
        if (lb_write && in_range) begin
            staging_d[lb_addr] = lb_data;
        end
        if (snap) begin
            latched_d = staging_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < consts_len; i++) begin
                staging_q[i] <= '0;
                latched_q[i] <= '0;
            end
        end else begin
            staging_q <= staging_d;
            latched_q <= latched_d;
        end
    end

    assign rd_data = latched_q[rd_idx];

endmodule

// File: rtl/sf_param_loader.sv
// Host-side constant loader: stages local-bus writes, snapshots them on commit
// and flushes the snapshot into the sf_user constant DPRAM during quiet windows.
module sf_param_loader
    import sf_param_loader_pkg::*;
#(
    parameter int pw         = 18,
    parameter int consts_len = 4,
    parameter int const_aw   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ce,
    input  logic                lb_write,
    input  logic [const_aw-1:0] lb_addr,
    input  logic [pw-1:0]       lb_data,
    input  logic                commit,
    input  logic                quiet,
    output logic                h_write,
    output logic [const_aw-1:0] h_addr,
    output logic [pw-1:0]       h_data,
    output logic                busy,
    output logic                done,
    output logic [ABORT_W-1:0]  abort_count
);

    localparam logic [const_aw-1:0] LAST_IDX  = const_aw'(consts_len - 1);
    localparam logic [ABORT_W-1:0]  ABORT_MAX = '1;

    sf_state_e            state_q, state_d;
    logic [const_aw-1:0]  idx_q, idx_d;
    logic                 done_q, done_d;
    logic [ABORT_W-1:0]   abort_q, abort_d;
    logic [pw-1:0]        rd_data;

    sf_param_bank #(
        .pw         (pw),
        .consts_len (consts_len),
        .const_aw   (const_aw)
    ) u_bank (
        .clk      (clk),
        .rst_n    (rst_n),
        .lb_write (lb_write),
        .lb_addr  (lb_addr),
        .lb_data  (lb_data),
        .snap     (ce & commit),
        .rd_idx   (idx_q),
        .rd_data  (rd_data)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = done_q;
        abort_d = abort_q;
        if (ce) begin
            done_d = 1'b0;
            if (commit) begin
                state_d = WAIT;
                idx_d   = '0;
            end else begin
                unique case (state_q)
                    WAIT: begin
                        if (quiet) begin
                            state_d = FLUSH;
                            idx_d   = '0;
                        end
                    end
                    FLUSH: begin
                        if (!quiet) begin
                            state_d = WAIT;
                            idx_d   = '0;
                            if (abort_q != ABORT_MAX) begin
                                abort_d = abort_q + 1'b1;
                            end
                        end else if (idx_q == LAST_IDX) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
            abort_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

    // The DPRAM qualifies h_write with ce itself, so no ce term here.
    assign h_write     = (state_q == FLUSH) && quiet;
    assign h_addr      = (state_q == FLUSH) ? idx_q   : '0;
    assign h_data      = (state_q == FLUSH) ? rd_data : '0;
    assign busy        = (state_q == WAIT) || (state_q == FLUSH);
    assign done        = done_q;
    assign abort_count = abort_q;

endmodule

// File: tb/tb_sf_param_loader.sv
// Directed bench for sf_param_loader with a behavioural model of the DPRAM
// host write port that records every qualified write.
module tb_sf_param_loader;

    localparam int PW  = 18;
    localparam int LEN = 4;
    localparam int AW  = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ce;
    logic          lb_write;
    logic [AW-1:0] lb_addr;
    logic [PW-1:0] lb_data;
    logic          commit;
    logic          quiet;
    logic          h_write;
    logic [AW-1:0] h_addr;
    logic [PW-1:0] h_data;
    logic          busy;
    logic          done;
    logic [7:0]    abort_count;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    logic [PW-1:0] mem [LEN];
    logic [PW-1:0] exp_w [LEN];
    int            log_addr [$];
    logic [PW-1:0] log_data [$];
    int            log_edge [$];

    sf_param_loader #(
        .pw         (PW),
        .consts_len (LEN),
        .const_aw   (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ce          (ce),
        .lb_write    (lb_write),
        .lb_addr     (lb_addr),
        .lb_data     (lb_data),
        .commit      (commit),
        .quiet       (quiet),
        .h_write     (h_write),
        .h_addr      (h_addr),
        .h_data      (h_data),
        .busy        (busy),
        .done        (done),
        .abort_count (abort_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n = edge_n + 1;

    // Inputs only change 1ns after a rising edge, so values seen here are
    // exactly what the DPRAM samples at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && ce && h_write) begin
            mem[h_addr] = h_data;
            log_addr.push_back(int'(h_addr));
            log_data.push_back(h_data);
            log_edge.push_back(edge_n + 1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        log_edge.delete();
    endtask

    task automatic wr(input int a, input logic [PW-1:0] d);
        lb_write = 1'b1;
        lb_addr  = AW'(a);
        lb_data  = d;
        tick();
        lb_write = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ce = 1'b1; lb_write = 1'b0; lb_addr = '0; lb_data = '0;
        commit = 1'b0; quiet = 1'b1;
        for (int i = 0; i < LEN; i++) mem[i] = '0;
        #12;
        checks++;
        if ({h_write, h_addr, h_data, busy, done, abort_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got w=%b a=%0d d=%h busy=%b done=%b ac=%0d, want all 0",
                     h_write, h_addr, h_data, busy, done, abort_count);
        end
        #11 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_flush();
        int n;
        exp_w[0] = 18'h00011; exp_w[1] = 18'h00022; exp_w[2] = 18'h00033; exp_w[3] = 18'h3FFFF;
        for (int i = 0; i < LEN; i++) wr(i, exp_w[i]);
        clear_log();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        n = edge_n;
        checks++;
        if (busy !== 1'b1 || h_write !== 1'b0) begin
            errors++;
            $display("FAIL basic_wait: busy=%b h_write=%b, want 1 0", busy, h_write);
        end
        for (int k = 0; k < LEN; k++) begin
            tick();
            checks++;
            if (h_write !== 1'b1 || h_addr !== AW'(k) || h_data !== exp_w[k]) begin
                errors++;
                $display("FAIL basic_word%0d: w=%b a=%0d d=%h, want 1 %0d %h",
                         k, h_write, h_addr, h_data, k, exp_w[k]);
            end
        end
        tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || h_write !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: done=%b busy=%b w=%b, want 1 0 0", done, busy, h_write);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_clear: done=%b, want 0", done);
        end
        checks++;
        if (log_addr.size() != LEN) begin
            errors++;
            $display("FAIL basic_write_count: got %0d, want %0d", log_addr.size(), LEN);
        end else begin
            for (int k = 0; k < LEN; k++) begin
                checks++;
                if (log_addr[k] != k || log_data[k] !== exp_w[k] || log_edge[k] != n + 2 + k
                    || mem[k] !== exp_w[k]) begin
                    errors++;
                    $display("FAIL basic_log%0d: a=%0d d=%h edge=%0d mem=%h, want %0d %h %0d %h",
                             k, log_addr[k], log_data[k], log_edge[k], mem[k], k, exp_w[k], n + 2 + k, exp_w[k]);
                end
            end
        end
    endtask

    task automatic test_quiet_gating();
        bit ok;
        quiet = 1'b0;
        clear_log();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (busy !== 1'b1 || h_write !== 1'b0) begin
                errors++;
                $display("FAIL quiet_hold%0d: busy=%b w=%b, want 1 0", i, busy, h_write);
            end
        end
        quiet = 1'b1;
        tick();
        checks++;
        if (h_write !== 1'b1 || h_addr !== '0 || h_data !== exp_w[0]) begin
            errors++;
            $display("FAIL quiet_start: w=%b a=%0d d=%h, want 1 0 %h", h_write, h_addr, h_data, exp_w[0]);
        end
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            if (done === 1'b1) ok = 1'b1;
        end
        checks++;
        if (!ok || log_addr.size() != LEN) begin
            errors++;
            $display("FAIL quiet_flush: done_seen=%b writes=%0d, want 1 %0d", ok, log_addr.size(), LEN);
        end
    endtask

    task automatic test_abort_retry();
        bit ok;
        quiet = 1'b1;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        repeat (3) tick();
        checks++;
        if (h_addr !== 2'd2 || h_write !== 1'b1) begin
            errors++;
            $display("FAIL abort_at_idx2: a=%0d w=%b, want 2 1", h_addr, h_write);
        end
        quiet = 1'b0;
        #1;
        checks++;
        if (h_write !== 1'b0) begin
            errors++;
            $display("FAIL abort_comb_gate: w=%b, want 0", h_write);
        end
        tick();
        checks++;
        if (abort_count !== 8'd1 || busy !== 1'b1 || h_write !== 1'b0 || h_addr !== '0) begin
            errors++;
            $display("FAIL abort_state: ac=%0d busy=%b w=%b a=%0d, want 1 1 0 0",
                     abort_count, busy, h_write, h_addr);
        end
        clear_log();
        quiet = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            if (done === 1'b1) ok = 1'b1;
        end
        checks++;
        if (!ok || log_addr.size() != LEN) begin
            errors++;
            $display("FAIL abort_retry: done_seen=%b writes=%0d, want 1 %0d", ok, log_addr.size(), LEN);
        end else begin
            for (int k = 0; k < LEN; k++) begin
                checks++;
                if (log_addr[k] != k || log_data[k] !== exp_w[k]) begin
                    errors++;
                    $display("FAIL abort_retry_word%0d: a=%0d d=%h, want %0d %h",
                             k, log_addr[k], log_data[k], k, exp_w[k]);
                end
            end
        end
    endtask

    task automatic test_commit_restart();
        bit ok;
        quiet = 1'b1;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        tick();
        wr(3, 18'h12345);
        exp_w[3] = 18'h12345;
        checks++;
        if (h_addr !== 2'd1 || h_write !== 1'b1) begin
            errors++;
            $display("FAIL restart_at_idx1: a=%0d w=%b, want 1 1", h_addr, h_write);
        end
        commit = 1'b1;
        tick();
        commit = 1'b0;
        clear_log();
        checks++;
        if (busy !== 1'b1 || h_write !== 1'b0) begin
            errors++;
            $display("FAIL restart_wait: busy=%b w=%b, want 1 0", busy, h_write);
        end
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            if (done === 1'b1) ok = 1'b1;
        end
        checks++;
        if (!ok || log_addr.size() != LEN) begin
            errors++;
            $display("FAIL restart_flush: done_seen=%b writes=%0d, want 1 %0d", ok, log_addr.size(), LEN);
        end else begin
            for (int k = 0; k < LEN; k++) begin
                checks++;
                if (log_addr[k] != k || log_data[k] !== exp_w[k]) begin
                    errors++;
                    $display("FAIL restart_word%0d: a=%0d d=%h, want %0d %h",
                             k, log_addr[k], log_data[k], k, exp_w[k]);
                end
            end
        end
        checks++;
        if (abort_count !== 8'd1) begin
            errors++;
            $display("FAIL restart_abort_count: got %0d, want 1", abort_count);
        end
    endtask

    task automatic test_bypass_ce();
        int n;
        int dcnt;
        quiet = 1'b1;
        ce = 1'b1;
        clear_log();
        lb_write = 1'b1; lb_addr = 2'd1; lb_data = 18'h0ABCD;
        commit = 1'b1;
        tick();
        lb_write = 1'b0;
        commit = 1'b0;
        exp_w[1] = 18'h0ABCD;
        n = edge_n;
        ce = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done === 1'b1) dcnt++;
            ce = ~ce;
        end
        ce = 1'b1;
        checks++;
        if (dcnt != 2) begin
            errors++;
            $display("FAIL ce_done_width: got %0d clk, want 2", dcnt);
        end
        checks++;
        if (log_addr.size() != LEN) begin
            errors++;
            $display("FAIL ce_write_count: got %0d, want %0d", log_addr.size(), LEN);
        end else begin
            for (int k = 0; k < LEN; k++) begin
                checks++;
                if (log_addr[k] != k || log_data[k] !== exp_w[k] || log_edge[k] != n + 4 + 2 * k) begin
                    errors++;
                    $display("FAIL bypass_word%0d: a=%0d d=%h edge=%0d, want %0d %h %0d",
                             k, log_addr[k], log_data[k], log_edge[k], k, exp_w[k], n + 4 + 2 * k);
                end
            end
        end
    endtask

    task automatic test_abort_saturate();
        bit ok;
        quiet = 1'b1;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        for (int a = 2; a <= 300; a++) begin
            tick();
            quiet = 1'b0;
            tick();
            quiet = 1'b1;
            if (a == 254 || a == 255 || a == 300) begin
                checks++;
                if (abort_count !== 8'(a > 255 ? 255 : a)) begin
                    errors++;
                    $display("FAIL abort_sat_%0d: got %0d, want %0d", a, abort_count, a > 255 ? 255 : a);
                end
            end
        end
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            if (done === 1'b1) ok = 1'b1;
        end
        checks++;
        if (!ok || abort_count !== 8'd255) begin
            errors++;
            $display("FAIL abort_sat_final: done_seen=%b ac=%0d, want 1 255", ok, abort_count);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        quiet = 1'b1;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        repeat (3) tick();
        checks++;
        if (h_addr !== 2'd2) begin
            errors++;
            $display("FAIL reset_pre_idx: a=%0d, want 2", h_addr);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({h_write, h_addr, h_data, busy, done, abort_count} !== '0) begin
            errors++;
            $display("FAIL async_reset: w=%b a=%0d d=%h busy=%b done=%b ac=%0d, want all 0",
                     h_write, h_addr, h_data, busy, done, abort_count);
        end
        #2 rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || h_write !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b w=%b, want 0 0", busy, h_write);
        end
        clear_log();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            if (done === 1'b1) ok = 1'b1;
        end
        checks++;
        if (!ok || log_addr.size() != LEN) begin
            errors++;
            $display("FAIL reset_reflush: done_seen=%b writes=%0d, want 1 %0d", ok, log_addr.size(), LEN);
        end else begin
            for (int k = 0; k < LEN; k++) begin
                checks++;
                if (log_addr[k] != k || log_data[k] !== '0 || mem[k] !== '0) begin
                    errors++;
                    $display("FAIL reset_zero_word%0d: a=%0d d=%h mem=%h, want %0d 0 0",
                             k, log_addr[k], log_data[k], mem[k], k);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_flush();
        test_quiet_gating();
        test_abort_retry();
        test_commit_restart();
        test_bypass_ce();
        test_abort_saturate();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
